// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one multi-cycle signed 18x18 multiplier among NUM_REQ requesters.
// The winner's operands are latched at grant and held until its tagged 36-bit product is returned.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [18*NUM_REQ-1:0] req_a,
    input  logic [18*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [35:0]           rsp_p,
    output logic                  mul_start,
    output logic [17:0]           mul_a,
    output logic [17:0]           mul_b,
    input  logic                  mul_busy,
    input  logic [35:0]           mul_p
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   cur_id;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [17:0]       grant_a;
    logic [17:0]       grant_b;
    int                best_dist;
    int                cand_dist;
    logic              issue;
    logic              done;

    // Winner is the set request with the smallest rotational distance past last_grant.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        grant_a      = '0;
        grant_b      = '0;
        best_dist    = NUM_REQ;
        cand_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_dist = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (req[i] && cand_dist < best_dist) begin
                best_dist    = cand_dist;
                grant_valid  = 1'b1;
                grant_idx    = ID_W'(i);
                grant_onehot = '0;
                grant_onehot[i] = 1'b1;
                grant_a      = req_a[18*i +: 18];
                grant_b      = req_b[18*i +: 18];
            end
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                // The busy guard also covers a multiplier still running after an arbiter reset.
                if (grant_valid && !mul_busy) begin
                    issue      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (mul_busy) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!mul_busy) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            req_ack    <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_p      <= '0;
        end else begin
            req_ack   <= '0;
            mul_start <= 1'b0;
            rsp_valid <= 1'b0;
            if (issue) begin
                last_grant <= grant_idx;
                cur_id     <= grant_idx;
                req_ack    <= grant_onehot;
                mul_start  <= 1'b1;
                mul_a      <= grant_a;
                mul_b      <= grant_b;
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_p     <= mul_p;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios plus a randomized run
// against a round-robin reference model, with a 4-cycle behavioural multiplier.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [18*NUM_REQ-1:0] req_a = '0;
    logic [18*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [35:0]           rsp_p;
    logic                  mul_start;
    logic [17:0]           mul_a;
    logic [17:0]           mul_b;
    logic                  mul_busy = 1'b0;
    logic [35:0]           mul_p = '0;

    int n_checks = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_start_busy = 0;
    int mul_cnt = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_p(mul_p)
    );

    function automatic logic [35:0] smul(input logic [17:0] a, input logic [17:0] b);
        logic signed [35:0] ea;
        logic signed [35:0] eb;
        ea = {{18{a[17]}}, a};
        eb = {{18{b[17]}}, b};
        return ea * eb;
    endfunction

    // Multiplier has no reset: busy for four cycles after a start, product valid as busy drops.
    always @(posedge clk) begin
        if (!mul_busy && mul_start) begin
            mul_busy <= 1'b1;
            mul_cnt  <= 4;
        end else if (mul_busy) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1) begin
                mul_busy <= 1'b0;
                mul_p    <= smul(mul_a, mul_b);
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start === 1'b1) begin
            n_start++;
            if (mul_busy) n_start_busy++;
        end
    end

    function automatic int rand18();
        return int'($urandom_range(262143)) - 131072;
    endfunction

    function automatic longint p2l(input logic [35:0] p);
        return longint'($signed(p));
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[18*i +: 18] = 18'(a);
        req_b[18*i +: 18] = 18'(b);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (req_ack === '0 && n < 40);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (rsp_valid !== 1'b1 && n < 40);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) step();
        n_checks++; if (req_ack !== '0) $display("FAIL reset_req_ack: got %b want 0", req_ack); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else n_pass++;
        n_checks++; if (rsp_p !== '0) $display("FAIL reset_rsp_p: got %h want 0", rsp_p); else n_pass++;
        n_checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b want 0", mul_start); else n_pass++;
        n_checks++; if (mul_a !== '0) $display("FAIL reset_mul_a: got %h want 0", mul_a); else n_pass++;
        n_checks++; if (mul_b !== '0) $display("FAIL reset_mul_b: got %h want 0", mul_b); else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (req_ack !== '0 || mul_start !== 1'b0)
            $display("FAIL idle_no_req: got ack=%b start=%b want 0/0", req_ack, mul_start);
        else n_pass++;
    endtask

    task automatic test_single();
        int n;
        int s0;
        s0 = n_start;
        set_ops(0, 3, -5);
        req = 4'b0001;
        wait_ack(n);
        n_checks++;
        if (n != 1 || req_ack !== 4'b0001) $display("FAIL single_ack: got %b after %0d cycles want 0001 after 1", req_ack, n);
        else n_pass++;
        n_checks++; if (mul_start !== 1'b1) $display("FAIL single_start: got %b want 1", mul_start); else n_pass++;
        req = '0;
        wait_rsp(n);
        n_checks++;
        if (n != 6) $display("FAIL single_latency: got rsp at cycle %0d want 7", n + 1); else n_pass++;
        n_checks++;
        if (rsp_id !== 2'd0 || p2l(rsp_p) != -15) $display("FAIL single_rsp: got id=%0d p=%0d want id=0 p=-15", rsp_id, p2l(rsp_p));
        else n_pass++;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || p2l(rsp_p) != -15) $display("FAIL single_hold: got valid=%b p=%0d want 0/-15", rsp_valid, p2l(rsp_p));
        else n_pass++;
        n_checks++;
        if (n_start - s0 != 1) $display("FAIL single_start_count: got %0d want 1", n_start - s0); else n_pass++;
    endtask

    task automatic test_extremes();
        int     ea[2] = '{-131072, 131071};
        int     eb[2] = '{-131072, -131072};
        longint ep[2] = '{64'sd17179869184, -64'sd17179738112};
        int     n;
        for (int k = 0; k < 2; k++) begin
            set_ops(3, ea[k], eb[k]);
            req = 4'b1000;
            wait_ack(n);
            n_checks++; if (req_ack !== 4'b1000) $display("FAIL extreme_ack[%0d]: got %b want 1000", k, req_ack); else n_pass++;
            req = '0;
            wait_rsp(n);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || p2l(rsp_p) != ep[k])
                $display("FAIL extreme_rsp[%0d]: got id=%0d p=%0d want id=3 p=%0d", k, rsp_id, p2l(rsp_p), ep[k]);
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        int a0, b0, a2, b2, n, t;
        a0 = rand18(); b0 = rand18(); a2 = rand18(); b2 = rand18();
        set_ops(0, a0, b0);
        set_ops(2, a2, b2);
        req = 4'b0101;
        t = 0;
        wait_ack(n); t += n;
        n_checks++; if (t != 1 || req_ack !== 4'b0001) $display("FAIL cont_ack0: got %b at %0d want 0001 at 1", req_ack, t); else n_pass++;
        req[0] = 1'b0;
        wait_rsp(n); t += n;
        n_checks++;
        if (t != 7 || rsp_id !== 2'd0 || p2l(rsp_p) != longint'(a0) * longint'(b0))
            $display("FAIL cont_rsp0: got id=%0d p=%0d at %0d want id=0 p=%0d at 7", rsp_id, p2l(rsp_p), t, longint'(a0) * longint'(b0));
        else n_pass++;
        wait_ack(n); t += n;
        n_checks++; if (t != 8 || req_ack !== 4'b0100) $display("FAIL cont_ack2: got %b at %0d want 0100 at 8", req_ack, t); else n_pass++;
        req[2] = 1'b0;
        wait_rsp(n); t += n;
        n_checks++;
        if (t != 14 || rsp_id !== 2'd2 || p2l(rsp_p) != longint'(a2) * longint'(b2))
            $display("FAIL cont_rsp2: got id=%0d p=%0d at %0d want id=2 p=%0d at 14", rsp_id, p2l(rsp_p), t, longint'(a2) * longint'(b2));
        else n_pass++;
    endtask

    task automatic test_fairness();
        int a[NUM_REQ];
        int b[NUM_REQ];
        int n, w;
        logic [NUM_REQ-1:0] exp_ack;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            a[i] = rand18();
            b[i] = rand18();
            set_ops(i, a[i], b[i]);
        end
        req = '1;
        for (int k = 0; k < 8; k++) begin
            w = k % NUM_REQ;
            exp_ack = '0;
            exp_ack[w] = 1'b1;
            wait_ack(n);
            n_checks++;
            if (n != 1 || req_ack !== exp_ack) $display("FAIL fair_ack[%0d]: got %b after %0d want %b after 1", k, req_ack, n, exp_ack);
            else n_pass++;
            wait_rsp(n);
            if (k == 7) req = '0;
            n_checks++;
            if (rsp_id !== ID_W'(w) || p2l(rsp_p) != longint'(a[w]) * longint'(b[w]))
                $display("FAIL fair_rsp[%0d]: got id=%0d p=%0d want id=%0d p=%0d", k, rsp_id, p2l(rsp_p), w, longint'(a[w]) * longint'(b[w]));
            else n_pass++;
        end
    endtask

    task automatic test_operand_stability();
        int a, b, n;
        bit moved;
        a = rand18(); b = rand18();
        set_ops(1, a, b);
        req = 4'b0010;
        wait_ack(n);
        n_checks++; if (req_ack !== 4'b0010) $display("FAIL stab_ack: got %b want 0010", req_ack); else n_pass++;
        req = '0;
        moved = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            set_ops(1, rand18(), rand18());
            step();
            if (mul_a !== 18'(a) || mul_b !== 18'(b)) moved = 1'b1;
        end
        n_checks++; if (moved) $display("FAIL stab_operands: got moving mul_a/mul_b want held %h/%h", 18'(a), 18'(b)); else n_pass++;
        wait_rsp(n);
        n_checks++;
        if (n != 1 || p2l(rsp_p) != longint'(a) * longint'(b))
            $display("FAIL stab_product: got %0d want %0d", p2l(rsp_p), longint'(a) * longint'(b));
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int a, b, n, s0, sb0;
        s0  = n_start;
        sb0 = n_start_busy;
        set_ops(1, rand18(), rand18());
        req = 4'b0010;
        step();
        n_checks++; if (req_ack !== 4'b0010) $display("FAIL rmid_ack1: got %b want 0010", req_ack); else n_pass++;
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({req_ack, rsp_valid, rsp_id, rsp_p, mul_start, mul_a, mul_b} !== '0)
            $display("FAIL rmid_outputs_zero: got ack=%b v=%b id=%0d p=%h s=%b a=%h b=%h want all 0",
                     req_ack, rsp_valid, rsp_id, rsp_p, mul_start, mul_a, mul_b);
        else n_pass++;
        a = rand18(); b = rand18();
        set_ops(1, a, b);
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || mul_start !== 1'b0) $display("FAIL rmid_guard: got valid=%b start=%b want 0/0", rsp_valid, mul_start);
        else n_pass++;
        step();
        n_checks++;
        if (req_ack !== 4'b0010 || mul_start !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rmid_regrant: got ack=%b start=%b valid=%b want 0010/1/0", req_ack, mul_start, rsp_valid);
        else n_pass++;
        req = '0;
        wait_rsp(n);
        n_checks++;
        if (n != 6 || rsp_id !== 2'd1 || p2l(rsp_p) != longint'(a) * longint'(b))
            $display("FAIL rmid_rsp: got id=%0d p=%0d after %0d want id=1 p=%0d after 6", rsp_id, p2l(rsp_p), n, longint'(a) * longint'(b));
        else n_pass++;
        n_checks++;
        if (n_start - s0 != 2 || n_start_busy != sb0)
            $display("FAIL rmid_starts: got %0d starts (%0d while busy) want 2 (0)", n_start - s0, n_start_busy - sb0);
        else n_pass++;
    endtask

    task automatic test_random();
        int     ref_last, w, j, ack_t, t, served, exp_id;
        longint exp_p;
        logic [NUM_REQ-1:0] exp_ack;
        bit     inflight;
        apply_reset();
        ref_last = NUM_REQ - 1;
        served = 0; inflight = 1'b0; t = 0; ack_t = 0; exp_id = 0; exp_p = 0;
        req = '0;
        while (served < 24 && t < 3000) begin
            // Idle requesters churn their operands and occasionally raise a new request.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i]) begin
                    set_ops(i, rand18(), rand18());
                    if ($urandom_range(2) == 0) req[i] = 1'b1;
                end
            end
            step();
            t++;
            if (req_ack !== '0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (ref_last + k) % NUM_REQ;
                    if (w < 0 && req[j]) w = j;
                end
                exp_ack = '0;
                if (w >= 0) exp_ack[w] = 1'b1;
                n_checks++;
                if (req_ack !== exp_ack || inflight) $display("FAIL rand_ack: got %b want %b (busy=%0d)", req_ack, exp_ack, inflight);
                else n_pass++;
                if (w >= 0) begin
                    exp_id   = w;
                    exp_p    = longint'($signed(req_a[18*w +: 18])) * longint'($signed(req_b[18*w +: 18]));
                    ref_last = w;
                    req[w]   = 1'b0;
                end
                inflight = 1'b1;
                ack_t    = t;
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (!inflight || rsp_id !== ID_W'(exp_id) || p2l(rsp_p) != exp_p || t - ack_t != 6)
                    $display("FAIL rand_rsp: got id=%0d p=%0d lat=%0d want id=%0d p=%0d lat=6", rsp_id, p2l(rsp_p), t - ack_t, exp_id, exp_p);
                else n_pass++;
                inflight = 1'b0;
                served++;
            end
        end
        req = '0;
        n_checks++; if (served != 24) $display("FAIL rand_served: got %0d want 24", served); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_fairness();
        test_operand_stability();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
